// File: rtl/mux_scan.sv
// Registered N-channel multiplexer with manual select and auto-scan sequencing.
// Scan holds each channel for dwell+1 cycles and pulses wrap on each return to channel 0.
module mux_scan #(
    parameter int unsigned WIDTH    = 1,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned DWELL_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] d,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [DWELL_W-1:0]        dwell,
    output logic [WIDTH-1:0]          q,
    output logic [SEL_W-1:0]          q_ch,
    output logic                      q_valid,
    output logic                      wrap
);

    localparam logic [SEL_W-1:0] LastCh = SEL_W'(CHANNELS - 1);
    localparam logic [SEL_W:0]   NumCh  = (SEL_W + 1)'(CHANNELS);

    typedef enum logic [1:0] {StIdle, StManual, StScan} state_e;

    state_e               r_state;
    state_e               w_state_next;
    logic [SEL_W-1:0]     r_ch;
    logic [SEL_W-1:0]     w_ch_d;
    logic [SEL_W-1:0]     w_ch_adv;
    logic [DWELL_W-1:0]   r_cnt;
    logic [DWELL_W-1:0]   w_cnt_d;
    logic [WIDTH-1:0]     r_q;
    logic [WIDTH-1:0]     w_q_d;
    logic [SEL_W-1:0]     r_q_ch;
    logic [SEL_W-1:0]     w_q_ch_d;
    logic                 r_valid;
    logic                 w_valid_d;
    logic                 r_wrap;
    logic                 w_wrap_d;
    logic                 w_sel_in_range;

    // Out-of-range indices select nothing and yield zero.
    function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] data,
                                              input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] res;
        res = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            if (idx == SEL_W'(i)) begin
                res = data[i*WIDTH +: WIDTH];
            end
        end
        return res;
    endfunction

    assign w_sel_in_range = {1'b0, sel} < NumCh;
    assign w_ch_adv       = (r_ch == LastCh) ? '0 : r_ch + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // en=0 dominates; otherwise mode alone picks the active state.
    always_comb begin
        w_state_next = r_state;
        if (!en) begin
            w_state_next = StIdle;
        end else if (mode) begin
            w_state_next = StScan;
        end else begin
            w_state_next = StManual;
        end
    end

    always_comb begin
        w_q_d     = r_q;
        w_q_ch_d  = r_q_ch;
        w_valid_d = 1'b0;
        w_wrap_d  = 1'b0;
        w_ch_d    = r_ch;
        w_cnt_d   = r_cnt;
        unique case (w_state_next)
            StIdle: begin
            end
            StManual: begin
                w_q_d     = pick(d, sel);
                w_q_ch_d  = sel;
                w_valid_d = w_sel_in_range;
            end
            StScan: begin
                w_valid_d = 1'b1;
                if (r_state != StScan) begin
                    w_ch_d   = '0;
                    w_cnt_d  = dwell;
                    w_q_d    = pick(d, '0);
                    w_q_ch_d = '0;
                end else if (r_cnt != '0) begin
                    w_cnt_d  = r_cnt - 1'b1;
                    w_q_d    = pick(d, r_ch);
                    w_q_ch_d = r_ch;
                end else begin
                    w_ch_d   = w_ch_adv;
                    w_cnt_d  = dwell;
                    w_q_d    = pick(d, w_ch_adv);
                    w_q_ch_d = w_ch_adv;
                    w_wrap_d = (r_ch == LastCh);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= '0;
            r_q_ch  <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            r_ch    <= '0;
            r_cnt   <= '0;
        end else begin
            r_q     <= w_q_d;
            r_q_ch  <= w_q_ch_d;
            r_valid <= w_valid_d;
            r_wrap  <= w_wrap_d;
            r_ch    <= w_ch_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign q       = r_q;
    assign q_ch    = r_q_ch;
    assign q_valid = r_valid;
    assign wrap    = r_wrap;

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
Parametrised, registered N-channel multiplexer. It is the successor to the team's combinational 4:1 mux. It adds configurable data width and channel count, a registered output with a valid flag, and an auto-scan mode. Auto-scan steps through all channels with a programmable dwell time and flags each wrap-around. It is used as a channel sampler and sequencer in front of serial and monitor logic.

Parameters:
WIDTH, 1, bits per channel
CHANNELS, 4, number of input channels (>=2)
SEL_W, 2, select/index width; must satisfy 2**SEL_W >= CHANNELS
DWELL_W, 4, width of the dwell-count input

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
d  input  CHANNELS*WIDTH  packed channel data; channel i = d[i*WIDTH +: WIDTH]
en  input  1  block enable
mode  input  1  0 = manual select, 1 = auto-scan
sel  input  SEL_W  manual channel select
dwell  input  DWELL_W  scan hold count; each channel is held for dwell+1 cycles
q  output  WIDTH  registered selected data
q_ch  output  SEL_W  channel index that q was sampled from
q_valid  output  1  q/q_ch valid this cycle
wrap  output  1  one-cycle pulse when scan returns to channel 0

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). While rst_n=0:
  - q=0, q_ch=0, q_valid=0, wrap=0
  - state=IDLE, internal ch=0, cnt=0
  - Reset mid-scan aborts immediately. Scan restarts at channel 0 after release.
- States: IDLE, MANUAL, SCAN. All outputs are registered. Latency is 1 cycle from d/sel to q.
- Transitions (evaluated at each rising edge):
  - en=0 from any state -> IDLE.
  - IDLE, en=1: mode=0 -> MANUAL, mode=1 -> SCAN.
  - MANUAL, mode=1 -> SCAN.
  - SCAN, mode=0 -> MANUAL.
- IDLE:
  - q and q_ch hold their last value; q_valid=0, wrap=0.
- MANUAL (including the entry edge):
  - sel < CHANNELS: q<=d[sel], q_ch<=sel, q_valid<=1.
  - sel >= CHANNELS: q<=0, q_ch<=sel, q_valid<=0.
  - wrap<=0.
- SCAN entry edge (from IDLE or MANUAL):
  - ch<=0, cnt<=dwell, q<=d[0], q_ch<=0, q_valid<=1, wrap<=0.
  - Entry does not assert wrap.
- SCAN, subsequent edges:
  - cnt!=0: cnt<=cnt-1, q<=d[ch] (live resample), q_ch<=ch, wrap<=0.
  - cnt==0: ch_next = (ch==CHANNELS-1) ? 0 : ch+1. Then ch<=ch_next, cnt<=dwell, q<=d[ch_next], q_ch<=ch_next, and wrap<=(ch==CHANNELS-1).
  - The wrap pulse coincides with the first cycle q_ch=0 of the new sweep.
- dwell handling:
  - dwell is sampled only on entry and at each channel advance. Mid-dwell changes take effect at the next channel.
  - dwell=0 advances every cycle.
- Boundaries:
  - The ch counter never reaches values >= CHANNELS. This holds for non-power-of-2 CHANNELS too.
  - mode toggling every cycle is legal. Each entry to SCAN restarts at channel 0.
  - en and mode changing on the same edge: en=0 wins.

Test Plan:
1. Manual sweep (WIDTH=1, CHANNELS=4): en=1, mode=0. For d=0..15, step sel=0..3 one cycle each -> each cycle after a sel change, q=d[sel], q_ch=sel, q_valid=1. Example: d=4'b1010 gives q sequence 0,1,0,1.
2. Out-of-range select (CHANNELS=3, SEL_W=2): sel=3 -> next cycle q=0, q_valid=0, q_ch=3. Then sel=2 -> q=d[2], q_valid=1.
3. Scan with dwell=0: d=4'b0110, mode=1 -> q_ch=0,1,2,3,0,1… and q=0,1,1,0,0,… with wrap=1 only on each q_ch=0 cycle after the first.
4. Scan with dwell=2 -> each q_ch value is held exactly 3 cycles, and wrap pulses every 12 cycles. Changing dwell to 0 mid-channel 1 shortens channel 2 onward, not channel 1.
5. Disable/mode switch: mid-scan en=0 -> q_valid=0, q/q_ch frozen. Re-enable -> restarts at q_ch=0. Scan -> mode=0 with sel=2 -> next cycle q_ch=2, wrap=0.
6. Async reset: assert rst_n=0 between clock edges during scan -> outputs go to 0 immediately, without waiting for clk. After release with en=1, mode=1 -> first valid cycle has q_ch=0, wrap=0.
